// File: rtl/mips16_boot_loader.sv
// Boot loader for mips_16: assembles a big-endian word-count-prefixed byte stream
// into 16-bit words, writes them to instruction memory and holds the CPU in reset until done.
module mips16_boot_loader #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int          IW      = ADDR_W + 1;
  localparam int          TW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [16:0] DEPTH_V = 17'(2 ** ADDR_W);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    CNT_HI  = 3'd0,
    CNT_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    WR      = 3'd4,
    RUN     = 3'd5,
    ERR     = 3'd6
  } state_t;

  state_t          state;
  logic [7:0]      n_hi;
  logic [7:0]      hi_byte;
  logic [15:0]     n_words;
  logic [IW-1:0]   idx;
  logic [TW-1:0]   idle_cnt;

  logic            rx_state;
  logic            accept;
  logic            timed_out;
  logic [15:0]     n_next;
  logic [IW-1:0]   idx_inc;
  logic            last_word;

  assign rx_state  = (state == CNT_HI) || (state == CNT_LO) ||
                     (state == DATA_HI) || (state == DATA_LO);
  assign rx_ready  = rx_state && !reset;
  assign accept    = rx_valid && rx_ready;
  assign n_next    = {n_hi, rx_data};
  assign idx_inc   = idx + 1'b1;
  assign last_word = (17'(idx_inc) == 17'(n_words));

  // CNT_HI waits forever; only the mid-frame states are watched for stalls.
  assign timed_out = ((state == CNT_LO) || (state == DATA_HI) || (state == DATA_LO)) &&
                     !accept && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CNT_HI;
      n_hi         <= 8'd0;
      hi_byte      <= 8'd0;
      n_words      <= 16'd0;
      idx          <= '0;
      idle_cnt     <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 16'd0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else if (reload) begin
      // A byte accepted in this same cycle is dropped on purpose.
      state        <= CNT_HI;
      n_words      <= 16'd0;
      idx          <= '0;
      idle_cnt     <= '0;
      imem_we      <= 1'b0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        CNT_HI: begin
          idle_cnt <= '0;
          if (accept) begin
            n_hi  <= rx_data;
            state <= CNT_LO;
          end
        end

        CNT_LO: begin
          if (accept) begin
            n_words  <= n_next;
            idle_cnt <= '0;
            if (n_next == 16'd0) begin
              state     <= RUN;
              cpu_reset <= 1'b0;
              load_done <= 1'b1;
            end else if (17'(n_next) > DEPTH_V) begin
              state    <= ERR;
              load_err <= 1'b1;
            end else begin
              state <= DATA_HI;
            end
          end else if (timed_out) begin
            state    <= ERR;
            load_err <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        DATA_HI: begin
          if (accept) begin
            hi_byte  <= rx_data;
            idle_cnt <= '0;
            state    <= DATA_LO;
          end else if (timed_out) begin
            state    <= ERR;
            load_err <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        DATA_LO: begin
          if (accept) begin
            imem_wdata <= {hi_byte, rx_data};
            imem_addr  <= idx[ADDR_W-1:0];
            imem_we    <= 1'b1;
            idle_cnt   <= '0;
            state      <= WR;
          end else if (timed_out) begin
            state    <= ERR;
            load_err <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        WR: begin
          idx          <= idx_inc;
          words_loaded <= idx_inc;
          idle_cnt     <= '0;
          if (last_word) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
            load_done <= 1'b1;
          end else begin
            state <= DATA_HI;
          end
        end

        RUN: state <= RUN;

        ERR: state <= ERR;

        default: begin
          state     <= CNT_HI;
          cpu_reset <= 1'b1;
          load_done <= 1'b0;
          load_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule
